// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared stage encodings and widths for the washing-machine blocks
package wm_pkg;

    localparam int STAGE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } wm_state_e;

endpackage

// File: rtl/stage_timer_if.sv
// rtl/stage_timer_if.sv - control/status bundle between the stage FSM and the stage timer
interface stage_timer_if #(
    parameter int CNT_W = wm_pkg::STAGE_W
);
    logic             start;
    logic [CNT_W-1:0] duration;
    logic             pause;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             done;
    logic             aborted;

    modport master (
        output start, duration, pause, abort,
        input  busy, remaining, done, aborted
    );

    modport slave (
        input  start, duration, pause, abort,
        output busy, remaining, done, aborted
    );
endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with a single-cycle rising-edge strobe
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/stage_timer.sv
// rtl/stage_timer.sv - counts a loaded stage duration down on slow-clock ticks
module stage_timer
    import wm_pkg::*;
#(
    parameter int CNT_W = STAGE_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slow_clk,
    stage_timer_if.slave  bus
);
    wm_state_e        state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             tick;

    edge_sync u_tick_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (slow_clk),
        .rise (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Abort outranks everything, so a start coinciding with abort in IDLE is dropped.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        if (bus.abort) begin
            if (state_q != IDLE) begin
                state_d     = IDLE;
                remaining_d = '0;
                aborted_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.duration != '0) begin
                            remaining_d = bus.duration;
                            state_d     = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        if (remaining_q > CNT_W'(1)) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = IDLE;
                            done_d      = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.remaining = remaining_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_stage_timer.sv
// tb/tb_stage_timer.sv - randomized scoreboard bench for stage_timer
module tb_stage_timer;

    logic clk;
    logic rst;
    logic slow_clk;

    stage_timer_if #(.CNT_W(8)) bus ();

    stage_timer #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .bus      (bus)
    );

    typedef struct {
        bit is_abort;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   e     = 0;
    bit   mon_en = 0;

    // Reference model: a stage is either inactive or counting, possibly frozen.
    bit   mdl_active = 0;
    bit   mdl_frozen = 0;
    int   mdl_rem    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, e);
        end
    endtask

    task automatic push_exp(input bit is_abort);
        exp_t x;
        x.is_abort = is_abort;
        x.edge_no  = e;
        q.push_back(x);
    endtask

    // Ticks land on edges 8 mod 10 given slow_clk = (e/5)%2 driven after edge e.
    task automatic model_step();
        bit tick;
        if (rst) return;
        tick = (e % 10 == 8);
        if (bus.abort) begin
            if (mdl_active) begin
                mdl_active = 0;
                mdl_frozen = 0;
                mdl_rem    = 0;
                push_exp(1'b1);
            end
        end else if (!mdl_active) begin
            if (bus.start) begin
                if (bus.duration != 0) begin
                    mdl_active = 1;
                    mdl_frozen = 0;
                    mdl_rem    = int'(bus.duration);
                end else begin
                    push_exp(1'b0);
                end
            end
        end else if (bus.pause) begin
            mdl_frozen = 1;
        end else if (mdl_frozen) begin
            mdl_frozen = 0;
        end else if (tick) begin
            if (mdl_rem > 1) begin
                mdl_rem = mdl_rem - 1;
            end else begin
                mdl_rem    = 0;
                mdl_active = 0;
                push_exp(1'b0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        e++;
        model_step();
        slow_clk = ((e / 5) % 2) == 1;
    endtask

    task automatic go_phase(input int p);
        cycle();
        for (int i = 0; i < 10 && (e % 10) != p; i++) cycle();
    endtask

    task automatic start_stage(input int d);
        go_phase(2);
        bus.start    = 1'b1;
        bus.duration = 8'(d);
        cycle();
        bus.start    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("busy", int'(bus.busy), int'(mdl_active));
            chk("remaining", int'(bus.remaining), mdl_rem);
            if (bus.done || bus.aborted) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", int'({bus.aborted, bus.done}), 0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("pulse_kind", int'({bus.aborted, bus.done}), x.is_abort ? 2 : 1);
                    chk("pulse_edge", e, x.edge_no);
                end
            end else if (q.size() > 0 && q[0].edge_no <= e) begin
                exp_t x;
                x = q.pop_front();
                chk("missed_pulse_at_edge", e, -x.edge_no);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", e);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        slow_clk     = 1'b0;
        bus.start    = 1'b0;
        bus.duration = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) cycle();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_remaining", int'(bus.remaining), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (5) cycle();
        chk("idle_done", int'(bus.done), 0);
        chk("idle_aborted", int'(bus.aborted), 0);

        // normal expiry
        start_stage(3);
        chk("normal_loaded", int'(bus.remaining), 3);
        repeat (35) cycle();

        // pause across two tick edges
        start_stage(5);
        go_phase(2);
        bus.pause = 1'b1;
        repeat (20) cycle();
        chk("pause_hold_rem", int'(bus.remaining), 4);
        bus.pause = 1'b0;
        repeat (45) cycle();

        // abort after two ticks
        start_stage(10);
        repeat (19) cycle();
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        chk("abort_rem", int'(bus.remaining), 0);
        repeat (10) cycle();

        // zero duration, then a late start during a run
        start_stage(0);
        chk("zero_busy", int'(bus.busy), 0);
        repeat (5) cycle();
        start_stage(4);
        repeat (12) cycle();
        bus.start    = 1'b1;
        bus.duration = 8'd7;
        cycle();
        bus.start    = 1'b0;
        repeat (45) cycle();

        // back-to-back: restart in the done cycle
        start_stage(1);
        go_phase(8);
        bus.start    = 1'b1;
        bus.duration = 8'd2;
        cycle();
        bus.start    = 1'b0;
        chk("b2b_rem", int'(bus.remaining), 2);
        repeat (30) cycle();

        // reset mid-run with slow_clk high at release
        start_stage(6);
        for (int i = 0; i < 40 && !(mdl_rem == 4 && (e % 10) == 6); i++) cycle();
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_aborted", int'(bus.aborted), 0);
        mdl_active = 0;
        mdl_frozen = 0;
        mdl_rem    = 0;
        q.delete();
        repeat (3) cycle();
        chk("release_slow_clk_high", int'(slow_clk), 1);
        rst = 1'b0;
        repeat (25) cycle();

        // randomized traffic
        repeat (1500) begin
            bus.start    = ($urandom_range(0, 14) == 0);
            bus.duration = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            bus.abort    = ($urandom_range(0, 99) == 0);
            cycle();
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        repeat (70) cycle();
        chk("pending_pulses", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_timer.md
# stage_timer

Countdown timer that consumes the divided slow clock and times each wash stage (fill, wash, rinse, spin). It runs on the fast system clock, synchronizes the divider's output, detects its rising edges as ticks, and counts a loaded duration down to zero. It reports `busy` while counting and a single-cycle `done` on expiry. It sits between the clock divider and the washing-machine stage FSM.

## Interface
- `CNT_W`, default 8: width of `duration` and `remaining`, in ticks.
- `clk` in 1: fast system clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `slow_clk` in 1: divided clock from the clock divider. Treated as data, never used as a clock.
- `start` in 1: load request, sampled only in IDLE.
- `duration` in CNT_W: tick count loaded when `start` is accepted.
- `pause` in 1: level signal (door open / lid interlock) that freezes the countdown.
- `abort` in 1: level or pulse that cancels the current stage.
- `busy` out 1: high in RUN and HOLD.
- `remaining` out CNT_W: ticks left in the current stage.
- `done` out 1: one-cycle pulse when a stage expires normally.
- `aborted` out 1: one-cycle pulse when an abort cancels an active stage.

## Operation
- **Synchronizer and edge detect:** `slow_clk` → sync1 → sync2 → prev, all reset to 0. `tick = sync2 & ~prev`.
- **States:** IDLE, RUN, HOLD.
- **Priority every cycle:** abort > start (IDLE only) > pause > tick.
- **IDLE:**
  - `start` with `duration != 0`: load `remaining = duration`, set `busy = 1`, go to RUN.
  - `start` with `duration == 0`: pulse `done` next cycle, stay in IDLE, `busy` stays 0.
  - Otherwise hold.
- **RUN:**
  - `pause = 1`: go to HOLD, `remaining` unchanged, a coincident tick is dropped.
  - Tick with `remaining > 1`: decrement `remaining`.
  - Tick with `remaining == 1`: `remaining = 0`, `busy = 0`, `done = 1`, go to IDLE.
- **HOLD:**
  - Ticks are ignored.
  - `pause = 0`: go to RUN. A tick in that same cycle is dropped.
- **Abort:**
  - In RUN or HOLD: `remaining = 0`, `busy = 0`, `aborted = 1`, go to IDLE, no `done`.
  - In IDLE: no effect, and a coincident `start` is ignored.
- **Ignored inputs:** `start` outside IDLE is ignored, with no reload and no restart.
- **Back-to-back stages:** `start` is accepted in the same cycle `done` is high, because the state is already IDLE.
- **Arithmetic:** `remaining` is unsigned and never wraps; no decrement below 0.
- **Reset (any time):**
  - State goes to IDLE; all outputs and synchronizer flops go to 0.
  - Mid-stage reset produces no `done` or `aborted` pulse.
  - A `slow_clk` that is high when reset releases produces one tick, which is harmless in IDLE.

## Timing
- **Reset values:** `busy = 0`, `done = 0`, `aborted = 0`, `remaining = 0`.
- **Start latency:** `start` sampled at edge N → `busy` and `remaining` updated at edge N.
- **Tick latency:** call E0 the first edge that samples `slow_clk` high. The tick is high in the cycle after E0+1, and `remaining` updates at edge E0+2.
- **Pulse width:** `done` and `aborted` are registered, high for exactly one clk cycle, and coincide with `busy` falling (zero-duration case excepted).
- **Tick rate:** with the divider at its default terminal count (100000000), one tick occurs every 200000002 clk cycles.

## Structure
- **Shared package `wm_pkg`:** the state encoding constants (IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2) and the default stage width. The stage FSM uses the same package.
- **Sub-module `edge_sync`:** 2-flop synchronizer plus rising-edge detector (`clk`, `rst`, `d_in`, `rise`). It is reusable for the door and start buttons.
- **Remainder:** one always block for the state, counter and pulses.

## Test plan
The bench drives `slow_clk` directly, toggling every 5 clk cycles, so one tick occurs every 10 cycles.
- **Normal expiry:** `start` with `duration = 3` → `busy` high for 3 ticks, `remaining` steps 3→2→1→0, and `done` is a single pulse with `busy` falling in the same cycle.
- **Pause:** `duration = 5`, `pause` held across 2 tick edges after the first decrement → `remaining` stays 4 during HOLD. On release, expiry occurs 4 ticks later.
- **Abort:** `duration = 10`, `abort` after 2 ticks → `remaining = 0`, `busy = 0`, one `aborted` pulse, no `done`.
- **Zero duration and late start:** `start` with `duration = 0` → `done` pulses next cycle and `busy` never rises. `start` with `duration = 7` mid-run → ignored, countdown continues.
- **Back-to-back:** `start` with `duration = 2` asserted in the `done` cycle → new stage loads immediately with `remaining = 2`.
- **Reset mid-run:** `rst` asserted mid-run with `remaining = 4` → all outputs 0 immediately, no pulses after release. A `slow_clk` high at release causes no state change.
